// File: rtl/rollercoaster_engine.sv
// Collatz (3n+1) sequence engine: steps a seed down to 1, tracking steps/peak.
// Ports: clock, reset_n, start, abort, seed -> numOut, steps, peak, busy, done, overflow.
// Optional: define RCNUM_PEAK_EN to keep the running-peak register.
module rollercoaster_engine #(
  parameter int WIDTH = 25,
  parameter int CNT_W = 16
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] seed,
  output logic [WIDTH-1:0] numOut,
  output logic [CNT_W-1:0] steps,
  output logic [WIDTH-1:0] peak,
  output logic             busy,
  output logic             done,
  output logic             overflow
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE,
    S_OVF
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] num_q, num_d;
  logic [CNT_W-1:0] steps_q, steps_d;
  logic [CNT_W-1:0] steps_inc;
  logic [WIDTH+1:0] tmp;
  logic             load;

  // 3n+1 as n + 2n + 1; two guard bits catch overflow
  assign tmp = {2'b00, num_q}
             + {1'b0, num_q, 1'b0}
             + (WIDTH+2)'(1);

  // saturate instead of wrapping
  assign steps_inc = (&steps_q) ? steps_q
                                : steps_q + CNT_W'(1);

  assign load = start && (state_q != S_RUN);

  always_comb begin
    state_d = state_q;
    num_d   = num_q;
    steps_d = steps_q;
    if (abort) begin
      state_d = S_IDLE;
    end else if (load) begin
      num_d   = seed;
      steps_d = '0;
      state_d = (seed == '0) ? S_OVF : S_RUN;
    end else if (state_q == S_RUN) begin
      if (num_q == WIDTH'(1)) begin
        state_d = S_DONE;
      end else if (!num_q[0]) begin
        num_d   = num_q >> 1;
        steps_d = steps_inc;
      end else if (|tmp[WIDTH+1:WIDTH]) begin
        num_d   = '0;
        state_d = S_OVF;
      end else begin
        num_d   = tmp[WIDTH-1:0];
        steps_d = steps_inc;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      num_q   <= '0;
      steps_q <= '0;
    end else begin
      state_q <= state_d;
      num_q   <= num_d;
      steps_q <= steps_d;
    end
  end

`ifdef RCNUM_PEAK_EN
  logic [WIDTH-1:0] peak_q, peak_d;

  // overflow step writes 0, so it never raises the peak
  always_comb begin
    peak_d = peak_q;
    if (!abort) begin
      if (load) begin
        peak_d = seed;
      end else if (state_q == S_RUN
                   && num_d > peak_q) begin
        peak_d = num_d;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      peak_q <= '0;
    end else begin
      peak_q <= peak_d;
    end
  end

  assign peak = peak_q;
`else
  assign peak = '0;
`endif

  assign numOut   = num_q;
  assign steps    = steps_q;
  assign busy     = (state_q == S_RUN);
  assign done     = (state_q == S_DONE);
  assign overflow = (state_q == S_OVF);

endmodule
